text_entry_scheduler: RTL and testbench
=======================================

// Module: text_entry_scheduler
// PURPOSE
//  Sequences all writes into the character buffer that feeds the font/tile renderer.
//  - Converts button presses and the 7-bit switch ASCII code into three operations:
//    put-character, backspace and clear-screen.
//  - Maintains the text cursor.
//  - Defers every buffer write to display blanking (valid_draw low) so that the
//    renderer never sees a half-updated cell.
//  - Sits between the board inputs and the char RAM write port, alongside
//    vga_controller.
// PARAMETERS
//  COLS    60  characters per row (480 px / 8 px glyph)
//  ROWS    17  character rows (272 px / 16 px glyph)
//  ADDR_W  11  char RAM address width; must satisfy COLS*ROWS <= 2**ADDR_W
// PORTS
//  clk         in   1       system clock; all logic on its rising edge
//  reset       in   1       asynchronous, active-low reset
//  en          in   1       high: accept new button events; low: events ignored, pending op held
//  btn         in   3       raw active-high buttons: [0] put, [1] backspace, [2] clear
//  sw          in   7       ASCII code written by put
//  valid_draw  in   1       high while renderer is in active area; writes allowed only when low
//  wr_en       out  1       char RAM write strobe, one clk per cell
//  wr_addr     out  ADDR_W  char RAM address = row*COLS + col
//  wr_data     out  7       char RAM data
//  cursor_row  out  5       current cursor row, 0..ROWS-1
//  cursor_col  out  6       current cursor column, 0..COLS-1
//  busy        out  1       high in any state other than IDLE
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - wr_en = 0; wr_addr = 0; wr_data = 0; cursor = (0,0); busy = 0; state = IDLE.
//   - Edge-detect registers clear to 0.
//  Input conditioning:
//   - btn passes through a 2-FF synchronizer; a rising edge on the synchronized value
//     creates a one-clk event.
//   - Total event latency is 3 clk from the raw edge.
//  Event acceptance:
//   - Events are accepted only in IDLE with en = 1; all other events are discarded
//     and are not queued.
//   - Simultaneous events: clear > backspace > put; lower-priority events in the same
//     cycle are discarded.
//   - sw is latched into wr_data in the accepting cycle; later sw changes have no effect.
//  State machine:
//   - IDLE -> PUT_WAIT | BS_WAIT | CLR_RUN on an accepted event.
//   - PUT_WAIT: when valid_draw = 0, pulse wr_en for 1 clk at the cursor address with the
//     latched code, then advance the cursor and go to IDLE.
//   - BS_WAIT: when valid_draw = 0, retreat the cursor and write 0x20 at the new position
//     in the same cycle, then go to IDLE.
//   - CLR_RUN:
//     - Scan address runs 0..COLS*ROWS-1; one wr_en per clk, data 0x20.
//     - Scanning only advances while valid_draw = 0 and pauses otherwise; one clear may
//       span several blanking intervals.
//     - After the last cell: cursor = (0,0), go to IDLE.
//   - en = 0 in any non-IDLE state freezes the state, holds wr_en = 0 and keeps the scan
//     address; the operation resumes when en returns high.
//  Cursor arithmetic:
//   - Advance: col+1; from col COLS-1 go to col 0, row+1; from (ROWS-1,COLS-1) go to (0,0).
//   - Retreat: col-1; from col 0 go to col COLS-1, row-1; at (0,0) stay at (0,0) and still
//     write 0x20 at address 0.
//   - Linear address is tracked incrementally alongside row/col (no multiplier). It wraps
//     at COLS*ROWS, not at 2**ADDR_W.
//  Outputs:
//   - wr_addr and wr_data are registered; they are valid whenever wr_en = 1 and are
//     otherwise don't-care.
//   - wr_en is never high while valid_draw = 1, measured in the same cycle.
//   - busy is high from the clk after acceptance until the clk after the final write.
//  Reset mid-operation:
//   - Aborts immediately; outputs take reset values.
//   - Char RAM contents are left as partially written; no recovery is attempted.
// TESTING
//  T1 sw=0x41, pulse btn[0], valid_draw=0 -> exactly one wr_en, addr 0, data 0x41;
//     cursor becomes (0,1); busy drops.
//  T2 cursor (0,59), put 0x42 -> write at addr 59; cursor becomes (1,0).
//     At (16,59), put -> write at addr 1019; cursor becomes (0,0).
//  T3 Cursor (1,0), pulse btn[1] -> write 0x20 at addr 59; cursor (0,59).
//     At (0,0), pulse btn[1] -> write 0x20 at addr 0; cursor stays (0,0).
//  T4 Pulse btn[2] with valid_draw toggling (1 for 400 clk, 0 for 100 clk)
//     -> 1020 writes of 0x20 at addresses 0..1019, each exactly once and in order;
//     none while valid_draw=1; cursor (0,0).
//  T5 btn[0] and btn[2] rise in the same clk -> only a clear occurs.
//     btn[0] pulsed during the clear -> discarded, no extra write.
//     en=0 during the clear -> scan freezes, then resumes at the same address.
//  T6 Assert reset 500 clk into a clear -> outputs go to reset values immediately;
//     after release, busy=0 and btn[0] writes at addr 0.

Source files
------------

// File: rtl/text_entry_scheduler_if.sv
// Character RAM write port bundle.
// Master drives one cell write per clk; slave is the char RAM.
interface text_entry_scheduler_if #(
  parameter int ADDR_W = 11
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [6:0]        wr_data;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport slave (
    input wr_en,
    input wr_addr,
    input wr_data
  );
endinterface

// File: rtl/text_entry_scheduler.sv
// Turns button events into put/backspace/clear writes to the char RAM.
// All writes are held off until the renderer is in blanking.
module text_entry_scheduler #(
  parameter int COLS   = 60,
  parameter int ROWS   = 17,
  parameter int ADDR_W = 11
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [2:0]              btn,
  input  logic [6:0]              sw,
  input  logic                    valid_draw,
  text_entry_scheduler_if.master  wr,
  output logic [4:0]              cursor_row,
  output logic [5:0]              cursor_col,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE,
    PUT_WAIT,
    BS_WAIT,
    CLR_RUN
  } state_t;

  localparam logic [5:0] COL_MAX = 6'(COLS - 1);
  localparam logic [4:0] ROW_MAX = 5'(ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(COLS * ROWS - 1);
  localparam logic [6:0] SPACE = 7'h20;

  state_t            state_q, state_d;
  logic [2:0]        btn_s1_q, btn_s2_q, btn_prev_q;
  logic [4:0]        row_q, row_d;
  logic [5:0]        col_q, col_d;
  logic [ADDR_W-1:0] caddr_q, caddr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [6:0]        wr_data_q, wr_data_d;

  logic [2:0]        evt;
  logic              go;
  logic              wr_en;
  logic [4:0]        adv_row, bs_row;
  logic [5:0]        adv_col, bs_col;
  logic [ADDR_W-1:0] adv_addr, bs_addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_s1_q   <= '0;
      btn_s2_q   <= '0;
      btn_prev_q <= '0;
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      caddr_q    <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      btn_s1_q   <= btn;
      btn_s2_q   <= btn_s1_q;
      btn_prev_q <= btn_s2_q;
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      caddr_q    <= caddr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Cursor neighbours; linear address moves by one alongside row/col
  always_comb begin
    adv_row  = row_q;
    adv_col  = col_q + 6'd1;
    adv_addr = caddr_q + 1'b1;
    if (col_q == COL_MAX) begin
      adv_col = '0;
      if (row_q == ROW_MAX) begin
        adv_row  = '0;
        adv_addr = '0;
      end else begin
        adv_row = row_q + 5'd1;
      end
    end
    bs_row  = row_q;
    bs_col  = col_q - 6'd1;
    bs_addr = caddr_q - 1'b1;
    if (col_q == '0) begin
      if (row_q == '0) begin
        bs_col  = '0;
        bs_addr = '0;
      end else begin
        bs_col = COL_MAX;
        bs_row = row_q - 5'd1;
      end
    end
  end

  always_comb begin
    evt       = btn_s2_q & ~btn_prev_q;
    go        = en & ~valid_draw;
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    caddr_d   = caddr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en && evt[2]) begin
          state_d   = CLR_RUN;
          wr_addr_d = '0;
          wr_data_d = SPACE;
        end else if (en && evt[1]) begin
          state_d   = BS_WAIT;
          wr_addr_d = bs_addr;
          wr_data_d = SPACE;
        end else if (en && evt[0]) begin
          state_d   = PUT_WAIT;
          wr_addr_d = caddr_q;
          wr_data_d = sw;
        end
      end
      PUT_WAIT: begin
        if (go) begin
          wr_en   = 1'b1;
          row_d   = adv_row;
          col_d   = adv_col;
          caddr_d = adv_addr;
          state_d = IDLE;
        end
      end
      BS_WAIT: begin
        if (go) begin
          wr_en   = 1'b1;
          row_d   = bs_row;
          col_d   = bs_col;
          caddr_d = bs_addr;
          state_d = IDLE;
        end
      end
      CLR_RUN: begin
        if (go) begin
          wr_en = 1'b1;
          if (wr_addr_q == LAST) begin
            row_d   = '0;
            col_d   = '0;
            caddr_d = '0;
            state_d = IDLE;
          end else begin
            wr_addr_d = wr_addr_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr.wr_en    = wr_en;
  assign wr.wr_addr  = wr_addr_q;
  assign wr.wr_data  = wr_data_q;
  assign cursor_row  = row_q;
  assign cursor_col  = col_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_text_entry_scheduler.sv
// Bench for text_entry_scheduler: directed and random ops checked
// against a linear-position cursor model and a model char RAM.
module tb_text_entry_scheduler;

  localparam int COLS  = 60;
  localparam int CELLS = 1020;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b1;
  logic       valid_draw = 1'b0;
  logic [2:0] btn = '0;
  logic [6:0] sw = '0;
  logic [4:0] cursor_row;
  logic [5:0] cursor_col;
  logic       busy;

  text_entry_scheduler_if #(.ADDR_W(11)) wr ();

  text_entry_scheduler #(.COLS(60), .ROWS(17), .ADDR_W(11)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .btn        (btn),
    .sw         (sw),
    .valid_draw (valid_draw),
    .wr         (wr),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] a;
    logic [6:0]  d;
  } wrec_t;

  int         checks = 0;
  int         passed = 0;
  wrec_t      wlog[$];
  logic [6:0] shadow[CELLS];
  logic [6:0] mram[CELLS];
  int         pos = 0;
  int         vd_mode = 0;
  int         vd_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (wr.wr_en === 1'b1) begin
      chk("wr_in_active", 32'(valid_draw), 0);
      wlog.push_back({wr.wr_addr, wr.wr_data});
      if (wr.wr_addr < CELLS) shadow[wr.wr_addr] = wr.wr_data;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (vd_mode)
        1: valid_draw = ($urandom % 4 == 0);
        2: begin
          valid_draw = (vd_cnt < 400);
          vd_cnt = (vd_cnt + 1) % 500;
        end
        default: valid_draw = 1'b0;
      endcase
    end
  end

  task automatic start(input logic [2:0] mask, input logic [6:0] code);
    wlog.delete();
    @(posedge clk); #1;
    sw  = code;
    btn = mask;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("busy_early", 32'(busy), 0);
    @(posedge clk); #1;
    chk("busy_latency", 32'(busy), 1);
    btn = '0;
    sw  = 7'($urandom);
  endtask

  task automatic finish(input logic [2:0] mask, input logic [6:0] code,
                        input int bound);
    int k;
    int n_exp;
    int bad;
    int ea;
    logic [6:0] ed;
    k = 0;
    while (busy === 1'b1 && k < bound) begin
      @(posedge clk); #1;
      k++;
    end
    chk("op_done", 32'(busy), 0);
    if (mask[2]) begin
      for (int i = 0; i < CELLS; i++) mram[i] = 7'h20;
      pos = 0; n_exp = CELLS; ea = CELLS - 1; ed = 7'h20;
    end else if (mask[1]) begin
      if (pos > 0) pos--;
      mram[pos] = 7'h20;
      n_exp = 1; ea = pos; ed = 7'h20;
    end else begin
      mram[pos] = code;
      n_exp = 1; ea = pos; ed = code;
      pos = (pos + 1) % CELLS;
    end
    chk("num_writes", wlog.size(), n_exp);
    if (wlog.size() > 0) begin
      chk("last_addr", 32'(wlog[$].a), ea);
      chk("last_data", 32'(wlog[$].d), 32'(ed));
    end
    if (mask[2]) begin
      bad = 0;
      foreach (wlog[i])
        if (int'(wlog[i].a) != i || wlog[i].d != 7'h20) bad++;
      chk("clear_order", bad, 0);
    end
    chk("cursor_row", 32'(cursor_row), pos / COLS);
    chk("cursor_col", 32'(cursor_col), pos % COLS);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [2:0] mask, input logic [6:0] code,
                    input int bound);
    start(mask, code);
    finish(mask, code, bound);
  endtask

  task automatic ram_chk(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < CELLS; i++)
      if (shadow[i] !== mram[i]) bad++;
    chk(tag, bad, 0);
  endtask

  initial begin
    int n0;
    logic [2:0] m;
    for (int i = 0; i < CELLS; i++) begin
      shadow[i] = '0;
      mram[i]   = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", 32'(wr.wr_en), 0);
    chk("rst_wr_addr", 32'(wr.wr_addr), 0);
    chk("rst_wr_data", 32'(wr.wr_data), 0);
    chk("rst_row", 32'(cursor_row), 0);
    chk("rst_col", 32'(cursor_col), 0);
    chk("rst_busy", 32'(busy), 0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    op(3'b001, 7'h41, 20);
    for (int i = 0; i < 58; i++) op(3'b001, 7'($urandom), 20);
    op(3'b001, 7'h42, 20);
    op(3'b010, 7'h00, 20);
    for (int i = 0; i < 960; i++) op(3'b001, 7'($urandom), 20);
    op(3'b001, 7'h43, 20);
    op(3'b010, 7'h00, 20);
    ram_chk("ram_directed");

    vd_mode = 2;
    op(3'b100, 7'h00, 8000);

    vd_mode = 0;
    op(3'b101, 7'h33, 2000);
    vd_mode = 1;
    start(3'b100, 7'h00);
    repeat (20) @(posedge clk);
    #1;
    btn = 3'b001;
    repeat (3) @(posedge clk);
    #1;
    btn = '0;
    repeat (20) @(posedge clk);
    #1;
    en = 1'b0;
    #1;
    n0 = wlog.size();
    repeat (50) @(posedge clk);
    #1;
    chk("freeze_count", wlog.size(), n0);
    chk("freeze_busy", 32'(busy), 1);
    en = 1'b1;
    finish(3'b100, 7'h00, 4000);
    repeat (10) @(posedge clk);
    #1;
    chk("no_late_write", wlog.size(), CELLS);
    ram_chk("ram_clear");

    vd_mode = 0;
    start(3'b100, 7'h00);
    repeat (500) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_wr_en", 32'(wr.wr_en), 0);
    chk("abort_wr_addr", 32'(wr.wr_addr), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_row", 32'(cursor_row), 0);
    chk("abort_col", 32'(cursor_col), 0);
    n0 = wlog.size();
    chk("abort_partial", 32'(n0 > 400 && n0 < CELLS), 1);
    for (int i = 0; i < n0; i++) mram[i] = 7'h20;
    pos = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    op(3'b001, 7'h55, 20);
    ram_chk("ram_abort");

    vd_mode = 1;
    for (int i = 0; i < 40; i++) begin
      n0 = $urandom % 16;
      if (n0 == 0)     m = 3'b100 | 3'($urandom % 4);
      else if (n0 < 5) m = 3'b010 | 3'($urandom % 2);
      else             m = 3'b001;
      op(m, 7'($urandom), 4000);
    end
    ram_chk("ram_random");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
